// File: rtl/mac8_pkg.sv
// Shared types and defaults for the mac8 job sequencer.
package mac8_pkg;

  localparam int ACC_W_DEF = 20;
  localparam int LEN_W_DEF = 8;

  typedef logic [7:0] operand_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac8_seq_ctrl_vedic.sv
// Shared 8x8 unsigned multiplier, built hierarchically from 2x2 vedic
// (Urdhva-Tiryagbhyam) cells. Purely combinational.
module vedic_8bit_multiplier
  import mac8_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 2x2 cell: vertical and crosswise partial products.
  function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    logic [3:0] r;
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  // 4x4 from four 2x2 cells, cross terms weighted by 4.
  function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] p0, p1, p2, p3;
    p0 = v2(x[1:0], y[1:0]);
    p1 = v2(x[3:2], y[1:0]);
    p2 = v2(x[1:0], y[3:2]);
    p3 = v2(x[3:2], y[3:2]);
    return {4'b0000, p0} + {2'b00, p1, 2'b00} + {2'b00, p2, 2'b00} + {p3, 4'b0000};
  endfunction

  // 8x8 from four 4x4 blocks, cross terms weighted by 16.
  function automatic logic [15:0] v8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q0, q1, q2, q3;
    q0 = v4(x[3:0], y[3:0]);
    q1 = v4(x[7:4], y[3:0]);
    q2 = v4(x[3:0], y[7:4]);
    q3 = v4(x[7:4], y[7:4]);
    return {8'h00, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0} + {q3, 8'h00};
  endfunction

  operand_t a_s, b_s;
  assign a_s = a;
  assign b_s = b;
  assign p   = v8(a_s, b_s);

endmodule

// File: rtl/mac8_seq_ctrl.sv
// mac8_seq_ctrl: job sequencer around one shared vedic 8x8 multiplier.
// Accepts a job length, streams operand pairs, registers each product and
// accumulates it; the sum is offered on a valid/ready result port.
// Optional build macro: MAC8_SATURATE_EN (clamp accumulator on carry-out
// instead of wrapping).
module mac8_seq_ctrl
  import mac8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]        prod_q, prod_d;
  logic               prod_vld_q, prod_vld_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [15:0]        prod_s;
  logic [ACC_W:0]     sum_s;

  vedic_8bit_multiplier u_mult (
    .a (a),
    .b (b),
    .p (prod_s)
  );

  // One extra bit above the accumulator captures the carry-out.
  assign sum_s = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod_q};

  // Next-state, accumulate and job bookkeeping.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    rem_d      = rem_q;

    if (prod_vld_q) begin
`ifdef MAC8_SATURATE_EN
      if (sum_s[ACC_W] || ovf_q) begin
        acc_d = {ACC_W{1'b1}};
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
`else
      acc_d = sum_s[ACC_W-1:0];
`endif
      if (sum_s[ACC_W]) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = {ACC_W{1'b0}};
          ovf_d = 1'b0;
          if (len != {LEN_W{1'b0}}) begin
            rem_d   = len;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          prod_d     = prod_s;
          prod_vld_d = 1'b1;
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      prod_q      <= 16'h0000;
      prod_vld_q  <= 1'b0;
      rem_q       <= {LEN_W{1'b0}};
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ST_RUN);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// Scoreboard bench for mac8_seq_ctrl: directed jobs push expected results,
// a monitor pops and compares on every result handshake.
module tb_mac8_seq_ctrl;

  localparam int ACC_W = 20;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       a = 8'd0;
  logic [7:0]       b = 8'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  exp_t sb[$];

  mac8_seq_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      hs_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(acc_out), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_acc", 32'(acc_out), 32'(e.acc));
        chk("sb_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_job();
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_out_valid();
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int hs0;
    exp_t e;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // 1: basic job, 12 + 200 + 65025
    e.acc = 20'd65237; e.ovf = 1'b0; sb.push_back(e);
    start_job(8'd3);
    send_pair(8'd3, 8'd4);
    send_pair(8'd10, 8'd20);
    send_pair(8'd255, 8'd255);
    @(negedge clk);
    chk("t1_drain_out_valid", 32'(out_valid), 32'd0);
    chk("t1_drain_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_out_valid_latency", 32'(out_valid), 32'd1);
    chk("t1_acc", 32'(acc_out), 32'd65237);
    finish_job();

    // 2: zero-length job
    e.acc = 20'd0; e.ovf = 1'b0; sb.push_back(e);
    start_job(8'd0);
    @(negedge clk);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_acc", 32'(acc_out), 32'd0);
    finish_job();

    // 3: gaps on input and stalled result
    e.acc = 20'd16; e.ovf = 1'b0; sb.push_back(e);
    start_job(8'd4);
    for (int i = 0; i < 4; i++) begin
      send_pair(8'd2, 8'd2);
      @(posedge clk);
      #1;
    end
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_out_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_acc", 32'(acc_out), 32'd16);
      @(negedge clk);
    end
    finish_job();

    // 4: overflow, 17 * 65025 = 1105425
`ifdef MAC8_SATURATE_EN
    e.acc = 20'hFFFFF;
`else
    e.acc = 20'd56849;
`endif
    e.ovf = 1'b1; sb.push_back(e);
    start_job(8'd17);
    for (int i = 0; i < 17; i++) send_pair(8'd255, 8'd255);
    wait_out_valid();
    chk("t4_ovf", 32'(overflow), 32'd1);
    finish_job();

    // 5: reset mid-job discards it
    start_job(8'd5);
    send_pair(8'd9, 8'd9);
    send_pair(8'd9, 8'd9);
    do_reset();
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_acc", 32'(acc_out), 32'd0);
    e.acc = 20'd63; e.ovf = 1'b0; sb.push_back(e);
    start_job(8'd1);
    send_pair(8'd7, 8'd9);
    finish_job();

    // 6: start while running is ignored
    hs0 = hs_cnt;
    e.acc = 20'd2; e.ovf = 1'b0; sb.push_back(e);
    start_job(8'd2);
    send_pair(8'd1, 8'd1);
    start_job(8'd1);
    send_pair(8'd1, 8'd1);
    finish_job();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t6_handshakes", 32'(hs_cnt - hs0), 32'd1);
    chk("t6_busy_after", 32'(busy), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac8_seq_ctrl.md
Name: mac8_seq_ctrl

Overview:
Job sequencer for the 8x8 unsigned multiply-accumulate datapath. It accepts a job length, then streams operand pairs through one shared instance of vedic_8bit_multiplier. Each product is registered and added into an accumulator. The final sum is presented on a valid/ready result port, so the MAC core runs as a self-timed job engine behind the chip I/O wrapper.

Parameters:
ACC_W, 20, accumulator and result width in bits (legal range 16..32).
LEN_W, 8, width of the job-length input. Maximum job is 2^LEN_W-1 pairs.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous active-high reset
start  input  1  job launch strobe; sampled only in IDLE
len  input  LEN_W  number of operand pairs in the job; sampled with start
in_valid  input  1  operand pair valid
in_ready  output  1  operand pair accepted when in_valid && in_ready
a  input  8  operand A, unsigned
b  input  8  operand B, unsigned
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
acc_out  output  ACC_W  accumulated sum of the job
overflow  output  1  sticky flag: some accumulation carried past ACC_W bits during the job
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; acc, prod_q, prod_vld_q, remaining and overflow cleared. All outputs 0 the following cycle. Reset mid-job discards the job entirely; there is no partial result.
- States:
  - IDLE: in_ready=0, out_valid=0, busy=0.
    - start && len!=0: load remaining=len, clear acc and overflow, go to RUN.
    - start && len==0: clear acc and overflow, go to DONE.
  - RUN: in_ready=1. On handshake, prod_q <= a*b (combinational vedic multiplier on the a/b ports), prod_vld_q <= 1, remaining decrements. If the accepted pair is the last one (remaining==1), go to DRAIN; in_ready is 0 from the next cycle.
  - DRAIN: in_ready=0. At the next edge the final prod_q is added, then go to DONE.
  - DONE: out_valid=1; acc_out and overflow held stable. On out_ready, go to IDLE; acc_out and overflow stay readable until the next start.
- Accumulate: every cycle prod_vld_q=1, acc <= acc + prod_q (zero-extended to ACC_W+1). prod_vld_q clears when no handshake occurs. Throughput is one pair per cycle, and in_valid gaps are allowed.
- Latency: the last pair accepted at edge E0 is summed at E0+1. out_valid is high in the cycle after E0+1.
- Overflow: if bit ACC_W of a sum is 1, overflow <= 1 (sticky until the next start). The default result wraps modulo 2^ACC_W.
- Edge cases:
  - start outside IDLE is ignored, and so is len.
  - in_valid outside RUN is ignored.
  - out_ready outside DONE is ignored.
  - Simultaneous start and out_ready in DONE: the job completes and goes to IDLE; that start is ignored.

Optional Feature:
MAC8_SATURATE_EN
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the job; overflow is still set.
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Package mac8_pkg: state enum (IDLE, RUN, DRAIN, DONE), default ACC_W/LEN_W constants, and an 8-bit operand typedef.
- Sub-module: one existing vedic_8bit_multiplier instance as the shared datapath. The controller and accumulator stay in mac8_seq_ctrl; no further sub-module is needed.

Test Plan:
1. Basic job: len=3, pairs (3,4), (10,20), (255,255) back-to-back. Expect acc_out=65237, overflow=0, out_valid 2 cycles after the last accept.
2. Zero-length job: start with len=0. Expect out_valid the cycle after the start edge, acc_out=0, and no in_ready pulse.
3. Back-pressure: len=4, (2,2) x4 with one-cycle in_valid gaps, out_ready held low for 5 cycles. Expect acc_out=16, with out_valid and acc_out stable throughout the stall.
4. Overflow: len=17, all (255,255). Expect acc_out=56849 and overflow=1; with MAC8_SATURATE_EN expect acc_out=0xFFFFF and overflow=1.
5. Reset mid-job: len=5, accept 2 pairs, assert rst for 1 cycle. Expect busy/in_ready/out_valid/acc_out=0; a new job len=1, (7,9) then gives 63.
6. Start during busy: pulse start with len=1 while in RUN of a len=2 job with (1,1),(1,1). Expect acc_out=2 and exactly one out_valid handshake.
